// File: rtl/carry_out_cascade_gen_if.sv
// Operand/sum handshake bundle for the
// carry_out_cascade_gen multi-word adder.
interface carry_out_cascade_gen_if #(
  parameter int DATA_W = 18
);
  logic              START;
  logic [1:0]        CARRYMUX_SEL;
  logic              CICAS;
  logic              CI;
  logic [DATA_W-1:0] A_IN;
  logic [DATA_W-1:0] B_IN;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] SUM_OUT;
  logic              SUM_VALID;
  logic              SUM_LAST;
  logic              CO;
  logic              COCAS;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, CARRYMUX_SEL, CICAS, CI,
    output A_IN, B_IN, IN_VALID,
    input  IN_READY, SUM_OUT, SUM_VALID,
    input  SUM_LAST, CO, COCAS, BUSY, DONE
  );

  modport slave (
    input  START, CARRYMUX_SEL, CICAS, CI,
    input  A_IN, B_IN, IN_VALID,
    output IN_READY, SUM_OUT, SUM_VALID,
    output SUM_LAST, CO, COCAS, BUSY, DONE
  );
endinterface

// File: rtl/carry_out_cascade_gen.sv
// Multi-word adder sequencer, LS word first,
// producing CO and cascade CO for the next slice.
module carry_out_cascade_gen #(
  parameter int DATA_W    = 18,
  parameter int NUM_WORDS = 4
) (
  input logic CLK,
  input logic RSTN,
  carry_out_cascade_gen_if.slave bus
);
  localparam int CNT_W =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  sum_q;
  logic               sv_q;
  logic               last_q;
  logic               done_q;
  logic               co_q;
  logic               cocas_q;

  logic               carry_d;
  logic [DATA_W:0]    add_d;
  logic               hs;
  logic               last_word;

  // Initial carry select, slice carry-in encoding
  always_comb begin
    carry_d = 1'b0;
    unique case (bus.CARRYMUX_SEL)
      2'b00:   carry_d = 1'b0;
      2'b01:   carry_d = 1'b1;
      2'b10:   carry_d = bus.CICAS;
      2'b11:   carry_d = bus.CI;
      default: carry_d = 1'b0;
    endcase
  end

  // Word adder and handshake decode
  always_comb begin
    add_d = {1'b0, bus.A_IN}
          + {1'b0, bus.B_IN}
          + {{DATA_W{1'b0}}, carry_q};
    hs        = (state_q == RUN) && bus.IN_VALID;
    last_word = (cnt_q == LAST_CNT);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sv_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
      cocas_q <= 1'b0;
    end else begin
      sv_q   <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.START) begin
            carry_q <= carry_d;
            cnt_q   <= '0;
            co_q    <= 1'b0;
            cocas_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            sum_q   <= add_d[DATA_W-1:0];
            sv_q    <= 1'b1;
            carry_q <= add_d[DATA_W];
            if (last_word) begin
              last_q  <= 1'b1;
              done_q  <= 1'b1;
              co_q    <= add_d[DATA_W];
              cocas_q <= add_d[DATA_W];
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = (state_q == RUN);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.SUM_OUT   = sum_q;
  assign bus.SUM_VALID = sv_q;
  assign bus.SUM_LAST  = last_q;
  assign bus.DONE      = done_q;
  assign bus.CO        = co_q;
  assign bus.COCAS     = cocas_q;
endmodule
